// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU; AND/OR/XOR/ADD/SUB in one cycle, MUL/DIV iterate over WIDTH cycles.
// Define ALU_ACCUM_EN to add the acc_sel_i port and a WIDTH-bit accumulator usable as operand A.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef ALU_ACCUM_EN
  input  logic               acc_sel_i,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               flag_zero_o,
  output logic               flag_carry_o,
  output logic               flag_dz_o
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready_o high
  // BUSY  | MUL/DIV iterating, one step per cycle
  // DONE  | result and flags held until consumed
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    work_q, work_d;
  logic [RW-1:0]    result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic [WIDTH-1:0] opa_in;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [RW-1:0]    single_res;
  logic             single_carry;

  logic [WIDTH:0]   mul_sum;
  logic [RW-1:0]    mul_step;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem_new;
  logic [RW-1:0]    div_step;
  logic [RW-1:0]    work_step;

`ifdef ALU_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  assign opa_in = acc_sel_i ? acc_q : a_i;
`else
  assign opa_in = a_i;
`endif

  assign accept   = in_valid_i && (state_q == ST_IDLE);
  assign add_sum  = {1'b0, opa_in} + {1'b0, b_i};
  assign sub_diff = opa_in - b_i;

  always_comb begin
    single_res   = '0;
    single_carry = 1'b0;
    case (op_i)
      OP_AND: single_res[WIDTH-1:0] = opa_in & b_i;
      OP_OR:  single_res[WIDTH-1:0] = opa_in | b_i;
      OP_XOR: single_res[WIDTH-1:0] = opa_in ^ b_i;
      OP_ADD: begin
        single_res[WIDTH:0] = add_sum;
        single_carry        = add_sum[WIDTH];
      end
      OP_SUB: begin
        single_res[WIDTH-1:0] = sub_diff;
        single_carry          = (opa_in < b_i);
      end
      default: ;
    endcase
  end

  // MUL: work = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, work_q[RW-1:WIDTH]} + (work_q[0] ? {1'b0, opa_q} : '0);
  assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

  // DIV: work = {remainder, dividend/quotient}, shifted left; B=0 naturally yields q=all ones, r=A.
  assign div_rem_sh  = work_q[RW-1:WIDTH-1];
  assign div_fits    = (div_rem_sh >= {1'b0, opb_q});
  assign div_diff    = div_rem_sh[WIDTH-1:0] - opb_q;
  assign div_rem_new = div_fits ? div_diff : div_rem_sh[WIDTH-1:0];
  assign div_step    = {div_rem_new, work_q[WIDTH-2:0], div_fits};

  assign work_step = is_div_q ? div_step : mul_step;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    dz_d     = dz_q;
`ifdef ALU_ACCUM_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opa_d = opa_in;
          opb_d = b_i;
          cnt_d = '0;
          if (op_i == OP_MUL) begin
            is_div_d = 1'b0;
            work_d   = {{WIDTH{1'b0}}, b_i};
            state_d  = ST_BUSY;
          end else if (op_i == OP_DIV) begin
            is_div_d = 1'b1;
            work_d   = {{WIDTH{1'b0}}, opa_in};
            state_d  = ST_BUSY;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            carry_d  = single_carry;
            dz_d     = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        work_d = work_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = work_step;
          zero_d   = (work_step == '0);
          carry_d  = is_div_q ? 1'b0 : (work_step[RW-1:WIDTH] != '0);
          dz_d     = is_div_q && (opb_q == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
`ifdef ALU_ACCUM_EN
          acc_d   = result_q[WIDTH-1:0];
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
`ifdef ALU_ACCUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      dz_q     <= dz_d;
`ifdef ALU_ACCUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign in_ready_o   = (state_q == ST_IDLE);
  assign out_valid_o  = (state_q == ST_DONE);
  assign result_o     = result_q;
  assign flag_zero_o  = zero_q;
  assign flag_carry_o = carry_q;
  assign flag_dz_o    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed vectors, expected responses queued at issue.
// Covers the accumulator case when ALU_ACCUM_EN is defined.
module tb_alu_seq;
  localparam int W = 8;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           z;
    logic           c;
    logic           dz;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
`ifdef ALU_ACCUM_EN
  logic           acc_sel = 1'b0;
`endif
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic           flag_zero;
  logic           flag_carry;
  logic           flag_dz;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
`ifdef ALU_ACCUM_EN
    .acc_sel_i   (acc_sel),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .flag_zero_o (flag_zero),
    .flag_carry_o(flag_carry),
    .flag_dz_o   (flag_dz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2*W-1:0] er, input logic ez, input logic ec, input logic edz);
    exp_t e;
    e.res = er;
    e.z   = ez;
    e.c   = ec;
    e.dz  = edz;
    exp_q.push_back(e);
  endtask

  // Monitor: inputs change on negedge only, so negedge+2 sees what the next posedge will use.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", result);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("flag_zero", flag_zero, e.z);
          chk("flag_carry", flag_carry, e.c);
          chk("flag_dz", flag_dz, e.dz);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [2*W-1:0] er, input logic ez, input logic ec, input logic edz,
                       input int elat, input string name);
    int n;
    int lat;
    logic rdy_bad;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_in_ready"}, in_ready, 1);
    push_exp(er, ez, ec, edz);
    in_valid = 1'b1;
    op = o;
    a = aa;
    b = bb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_ready_low"}, {rdy_bad, in_ready}, 0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_zero, flag_carry, flag_dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b1, 1'b0, 1, "add_carry");
    issue(OP_SUB, 8'd5,   8'd7,   16'h00FE, 1'b0, 1'b1, 1'b0, 1, "sub_borrow");
    issue(OP_SUB, 8'd7,   8'd7,   16'h0000, 1'b1, 1'b0, 1'b0, 1, "sub_equal");
    issue(OP_AND, 8'hF0,  8'h0F,  16'h0000, 1'b1, 1'b0, 1'b0, 1, "and_zero");
    issue(OP_OR,  8'hA0,  8'h05,  16'h00A5, 1'b0, 1'b0, 1'b0, 1, "or");
    issue(OP_ADD, 8'd255, 8'd1,   16'h0100, 1'b0, 1'b1, 1'b0, 1, "add_wrap");
    issue(OP_ILL, 8'd3,   8'd4,   16'h0000, 1'b1, 1'b0, 1'b0, 1, "illegal");
    issue(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b1, 1'b0, 9, "mul_max");
    issue(OP_MUL, 8'd16,  8'd16,  16'h0100, 1'b0, 1'b1, 1'b0, 9, "mul_hi");
    issue(OP_MUL, 8'd15,  8'd17,  16'h00FF, 1'b0, 1'b0, 1'b0, 9, "mul_lo");
    issue(OP_DIV, 8'd100, 8'd7,   16'h020E, 1'b0, 1'b0, 1'b0, 9, "div");
    issue(OP_DIV, 8'd9,   8'd0,   16'h09FF, 1'b0, 1'b0, 1'b1, 9, "div_zero");

    // Backpressure: DONE held with a new request pending.
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(OP_XOR, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1'b0, 1, "xor_bp");
    in_valid = 1'b1;
    op = OP_ADD;
    a = 8'd10;
    b = 8'd20;
    push_exp(16'h001E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_result", result, 16'h00FF);
      chk("bp_flags", {flag_zero, flag_carry, flag_dz}, 0);
      chk("bp_hold", {out_valid, in_ready}, 2'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    chk("bp_next_accept", {out_valid, in_ready}, 2'b10);
    in_valid = 1'b0;

    // Asynchronous reset in BUSY cycle 4 of a MUL.
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    op = OP_MUL;
    a = 8'd12;
    b = 8'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_ready_valid", {out_valid, in_ready}, 2'b01);
    chk("abort_result", result, 0);
    chk("abort_flags", {flag_zero, flag_carry, flag_dz}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0, 1'b0, 1, "add_after_rst");
`ifdef ALU_ACCUM_EN
    acc_sel = 1'b1;
    issue(OP_ADD, 8'h55, 8'd1, 16'h0008, 1'b0, 1'b0, 1'b0, 1, "acc_add");
    acc_sel = 1'b0;
`endif

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
